mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
//  Sits directly downstream of the register file: src_a/src_b come from rdata1/rdata2.
//  hi/lo feed the MFHI/MFLO path back to the write-back mux.
//  The control unit stalls the pipe while busy=1.
// PARAMETERS
//  WIDTH   32               operand / HI / LO width
//  CNT_W   $clog2(WIDTH)    iteration counter width
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      reset: synchronous, active-low
//  start    in   1      launch op; sampled only when busy=0
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src_a    in   WIDTH  rs operand (multiplicand / dividend)
//  src_b    in   WIDTH  rt operand (multiplier / divisor)
//  mthi     in   1      write wdata to HI (MTHI)
//  mtlo     in   1      write wdata to LO (MTLO)
//  wdata    in   WIDTH  MTHI/MTLO data
//  hi       out  WIDTH  HI register
//  lo       out  WIDTH  LO register
//  busy     out  1      operation in progress
//  done     out  1      one-cycle pulse; hi/lo hold the new result
// BEHAVIOUR
//  Reset: any edge with rst=0 does the following:
//   - state=IDLE, hi=lo=0, done=0, counter=0.
//   - Overrides every other input.
//   - Aborts an operation in flight: no done, no hi/lo update.
//  FSM IDLE->RUN->FIX->IDLE; busy = (state!=IDLE), combinational.
//  IDLE, start=1 at edge E0:
//   - Latch |src_a|, |src_b| (magnitude only for signed ops; raw for unsigned).
//   - Latch sign flags and op; counter=0; go to RUN.
//  RUN: one shift-add (mul) or restoring subtract (div) step per edge.
//   - At the edge with counter==WIDTH-1, go to FIX.
//   - RUN lasts WIDTH edges (E1..E32).
//  FIX (edge E33): apply sign fixup, write hi/lo, done<=1, state<=IDLE.
//   - Latency: start edge to result visible = 33 edges at WIDTH=32.
//   - done is high exactly one cycle.
//  Multiply result: {hi,lo} = 64-bit product.
//   - Signed: negate the product if sign_a^sign_b.
//  Divide result: lo = quotient, hi = remainder.
//   - Signed: quotient negated if sign_a^sign_b; remainder takes the sign of the dividend.
//   - 0x80000000 / -1 -> lo=0x80000000, hi=0 (natural wrap, no trap).
//  Divide by zero (defined, no trap): lo=0xFFFFFFFF, hi=src_a.
//   - Applies to signed and unsigned.
//   - Still takes the full 33 cycles and still pulses done.
//  start while busy: ignored; the in-flight op continues unaffected.
//  mthi/mtlo:
//   - Honoured only in IDLE; hi/lo update at the next edge.
//   - Both may assert in the same cycle; both registers are written.
//   - Ignored while busy; the control unit must stall them.
//  start and mthi/mtlo in the same IDLE cycle: the MT write lands.
//   - The op then launches and overwrites hi/lo at FIX.
//  hi/lo hold their value in RUN; they change only at FIX, on MT writes, or on reset.
// STRUCTURE
//  mdu_pkg (shared package):
//   - op encodings MDU_MULT/MULTU/DIV/DIVU.
//   - state enum IDLE/RUN/FIX.
//   - WIDTH default constant.
//   - divide-by-zero quotient constant.
//  One sub-module: mdu_div_step.
//   - Combinational restoring-division step.
//   - Inputs: {rem, quo}, divisor. Outputs: next {rem, quo}.
//   - Unit-testable in isolation.
//  Multiply step, sign fixup and FSM stay in the top module.
// TESTING
//  1 Reset: rst=0 for 1 edge mid-idle -> hi=lo=0, busy=0, done=0.
//  2 MULTU: src_a=src_b=0xFFFFFFFF, start 1 cycle.
//    -> busy 33 cycles; done at E33; hi=0xFFFFFFFE, lo=0x00000001.
//  3 MULT: -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//    DIV: -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  4 DIVU: 0x6C / 0 -> lo=0xFFFFFFFF, hi=0x0000006C, done pulses.
//    DIV: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
//  5 MT writes and start-while-busy:
//    - mthi=1, mtlo=1, wdata=0x1 in IDLE -> next cycle hi=lo=0x1.
//    - Repeat while busy -> hi/lo unchanged.
//    - start re-pulsed at E10 -> result and done timing unchanged.
//  6 Reset abort: MULTU 5x5 started, rst=0 at E10.
//    -> state IDLE, hi=lo=0, no done pulse.
//    -> A new start afterwards completes normally: lo=0x19.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states, default width and divide-by-zero quotient.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [MDU_WIDTH-1:0] MDU_DIV0_QUO = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on unsigned magnitudes.
// Shifts {rem,quo} left by one and subtracts the divisor when it fits.
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Partial remainder gains one dividend bit; it can exceed WIDTH bits.
  assign w_sh   = {i_rem, i_quo[WIDTH-1]};
  assign w_ge   = w_sh >= {1'b0, i_div};
  // True difference is below the divisor, so the low bits are exact.
  assign w_diff = w_sh[WIDTH-1:0] - i_div;
  assign o_rem  = w_ge ? w_diff : w_sh[WIDTH-1:0];
  assign o_quo  = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
// Works on magnitudes for WIDTH steps, then fixes signs in one cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  mdu_state_e r_state;
  mdu_state_e w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hw;
  logic [WIDTH-1:0] r_lw;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_src_a;
  logic             r_sa;
  logic             r_sb;
  logic             r_div;
  logic             r_done;

  logic             w_sgn;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_mul_hw;
  logic [WIDTH-1:0] w_mul_lw;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_dz;
  logic             w_last;

  assign w_sgn   = op_is_signed(op);
  assign w_sa    = w_sgn & src_a[WIDTH-1];
  assign w_sb    = w_sgn & src_b[WIDTH-1];
  assign w_mag_a = w_sa ? -src_a : src_a;
  assign w_mag_b = w_sb ? -src_b : src_b;

  // Shift-add: carry out of the add drops into the upper product half.
  assign w_sum    = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_opb} : '0);
  assign w_mul_hw = w_sum[WIDTH:1];
  assign w_mul_lw = {w_sum[0], r_lw[WIDTH-1:1]};

  mdu_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem (r_hw),
    .i_quo (r_lw),
    .i_div (r_opb),
    .o_rem (w_div_rem),
    .o_quo (w_div_quo)
  );

  assign w_prod     = {r_hw, r_lw};
  assign w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
  assign w_quo_fix  = (r_sa ^ r_sb) ? -r_lw : r_lw;
  assign w_rem_fix  = r_sa ? -r_hw : r_hw;
  assign w_dz       = (r_opb == '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH-1));

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, iteration, result write-back and MT writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_hw    <= '0;
      r_lw    <= '0;
      r_opb   <= '0;
      r_src_a <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_div   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (mthi) r_hi <= wdata;
          if (mtlo) r_lo <= wdata;
          if (start) begin
            r_cnt   <= '0;
            r_hw    <= '0;
            r_lw    <= op_is_div(op) ? w_mag_a : w_mag_b;
            r_opb   <= op_is_div(op) ? w_mag_b : w_mag_a;
            r_src_a <= src_a;
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_div   <= op_is_div(op);
          end
        end
        RUN: begin
          if (r_div) begin
            r_hw <= w_div_rem;
            r_lw <= w_div_quo;
          end else begin
            r_hw <= w_mul_hw;
            r_lw <= w_mul_lw;
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          r_done <= 1'b1;
          if (!r_div) begin
            {r_hi, r_lo} <= w_prod_fix;
          end else if (w_dz) begin
            r_lo <= WIDTH'(MDU_DIV0_QUO);
            r_hi <= r_src_a;
          end else begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit.
// Hand-computed vectors for mul/div, MT writes, busy/done timing, reset.
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  mult_div_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left on a negedge. mt_at/rs_at: busy sample index at which
  // to inject an MT write or a start pulse (-1 = never).
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] prev_hi,
                        input logic [31:0] prev_lo,
                        input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo,
                        input int mt_at, input int rs_at);
    int n;
    int early;
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    early = 0;
    while (busy && n < 200) begin
      if (n == 16) begin
        chk({tag, " hold_hi"}, hi, prev_hi);
        chk({tag, " hold_lo"}, lo, prev_lo);
      end
      if (done) early++;
      mthi  = (n == mt_at);
      mtlo  = (n == mt_at);
      start = (n == rs_at);
      if (n == mt_at) wdata = 32'hDEAD_BEEF;
      if (n == rs_at) begin
        op    = OP_MULTU;
        src_a = 32'd3;
        src_b = 32'd3;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    chk({tag, " busy_cycles"}, 32'(n), 32'd33);
    chk({tag, " early_done"}, 32'(early), 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    @(negedge clk);
    chk({tag, " done_drop"}, {31'd0, done}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dcount;
    rst   = 1'b0;
    start = 1'b0;
    op    = OP_MULT;
    src_a = '0;
    src_b = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);

    // MT write then one-edge reset mid-idle
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h55;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mt55 hi", hi, 32'h55);
    chk("mt55 lo", lo, 32'h55);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst2 hi", hi, 32'd0);
    chk("rst2 lo", lo, 32'd0);
    chk("rst2 busy", {31'd0, busy}, 32'd0);
    chk("rst2 done", {31'd0, done}, 32'd0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001, -1, -1);
    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, -1);
    run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           -1, -1);
    run_op("divu_dz", OP_DIVU, 32'h6C, 32'h0,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h6C, 32'hFFFF_FFFF, -1, -1);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h6C, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, -1, -1);

    // MT both registers in idle
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h1;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mt1 hi", hi, 32'h1);
    chk("mt1 lo", lo, 32'h1);

    // MT while busy and start re-pulse at E10 are both ignored
    run_op("busy_ign", OP_MULTU, 32'h1234_5678, 32'h10,
           32'h1, 32'h1, 32'h1, 32'h2345_6780, 5, 9);

    // MT and start in the same idle cycle: MT lands, op overwrites later
    mthi  = 1'b1;
    wdata = 32'hAA;
    run_op("mt_start", OP_DIVU, 32'd100, 32'd7,
           32'hAA, 32'h2345_6780, 32'h2, 32'hE, -1, -1);

    run_op("mult_5xm4", OP_MULT, 32'd5, 32'hFFFF_FFFC,
           32'h2, 32'hE, 32'hFFFF_FFFF, 32'hFFFF_FFEC, -1, -1);
    run_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
           32'hFFFF_FFFF, 32'hFFFF_FFEC, 32'h1, 32'hFFFF_FFFD, -1, -1);

    // Reset abort at E10
    op    = OP_MULTU;
    src_a = 32'd5;
    src_b = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_abort busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort no_done", 32'(dcount), 32'd0);

    run_op("after_abort", OP_MULTU, 32'd5, 32'd5,
           32'h0, 32'h0, 32'h0, 32'h19, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
